// File: rtl/piano_key_renderer_if.sv
// Pixel-write bus between the key-strip renderer and its environment:
// raw key inputs and enable in, vga_adapter pixel port and busy out.
interface piano_key_renderer_if #(
    parameter int NUM_KEYS = 8,
    parameter int X_W      = 8,
    parameter int Y_W      = 7
);
    logic [NUM_KEYS-1:0] key_n;
    logic                enable;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [2:0]          colour;
    logic                plot;
    logic                busy;

    // Environment side: drives the keys and enable, watches the pixel port.
    modport master (
        output key_n,
        output enable,
        input  x,
        input  y,
        input  colour,
        input  plot,
        input  busy
    );

    // Renderer side.
    modport slave (
        input  key_n,
        input  enable,
        output x,
        output y,
        output colour,
        output plot,
        output busy
    );
endinterface

// File: rtl/piano_key_renderer.sv
// Piano key-strip renderer: watches NUM_KEYS active-low keys and repaints
// each key whose on-screen state is stale as a KEY_W x KEY_H rectangle,
// one pixel per clock, serving stale keys round-robin.
module piano_key_renderer #(
    parameter int NUM_KEYS = 8,
    parameter int KEY_W    = 16,
    parameter int KEY_H    = 8,
    parameter int KEY_Y    = 87,
    parameter int X_W      = 8,
    parameter int Y_W      = 7
) (
    input  logic                  clk,
    input  logic                  resetn,
    piano_key_renderer_if.slave   vga
);

    localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FILL
    } state_e;

    state_e               state_q, state_d;

    logic [NUM_KEYS-1:0]  sync1_q, sync2_q;
    logic [NUM_KEYS-1:0]  live;
    logic [NUM_KEYS-1:0]  dirty;
    logic [NUM_KEYS-1:0]  drawn_q, drawn_d;

    logic [IDX_W-1:0]     last_q, last_d;
    logic [X_W-1:0]       base_x_q, base_x_d;
    logic [X_W-1:0]       col_q, col_d;
    logic [Y_W-1:0]       row_q, row_d;

    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic [2:0]           colour_q, colour_d;
    logic                 plot_q, plot_d;

    logic [IDX_W-1:0]     win;
    logic                 win_valid;
    logic [IDX_W-1:0]     cand;
    logic [2:0]           win_colour;
    logic [X_W-1:0]       win_base_x;
    logic                 last_px;

    // Two-flop synchroniser for the asynchronous key inputs; reset to released.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= vga.key_n;
            sync2_q <= sync1_q;
        end
    end

    // A key is stale whenever its live level differs from what was last drawn.
    assign live  = ~sync2_q;
    assign dirty = live ^ drawn_q;

    // Round-robin arbiter: first stale key found searching from last_served+1.
    // NOTE: every always_comb output gets a default first so that no path
    // leaves a variable unassigned and infers a latch.
    always_comb begin
        win       = '0;
        win_valid = 1'b0;
        cand      = '0;
        for (int off = 1; off <= NUM_KEYS; off++) begin
            cand = IDX_W'((int'(last_q) + off) % NUM_KEYS);
            if (!win_valid && dirty[cand]) begin
                win       = cand;
                win_valid = 1'b1;
            end
        end
    end

    // Pressed colour cycles through the seven non-black values; base x of the winner.
    assign win_colour = live[win] ? 3'((int'(win) % 7) + 1) : 3'b000;
    assign win_base_x = X_W'(int'(win) * KEY_W);

    assign last_px = (col_q == X_W'(KEY_W - 1)) && (row_q == Y_W'(KEY_H - 1));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, drawn bookkeeping and next pixel to present on the port.
    always_comb begin
        state_d  = state_q;
        drawn_d  = drawn_q;
        last_d   = last_q;
        base_x_d = base_x_q;
        col_d    = col_q;
        row_d    = row_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (vga.enable && |dirty) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (win_valid) begin
                    // Marking the key drawn here lets a change during its own
                    // fill re-raise dirty and queue a redraw.
                    drawn_d[win] = live[win];
                    last_d       = win;
                    base_x_d     = win_base_x;
                    col_d        = '0;
                    row_d        = '0;
                    x_d          = win_base_x;
                    y_d          = Y_W'(KEY_Y);
                    colour_d     = win_colour;
                    plot_d       = 1'b1;
                    state_d      = S_FILL;
                end else begin
                    // The change vanished before service (press/release glitch).
                    state_d = S_IDLE;
                end
            end

            S_FILL: begin
                if (last_px) begin
                    // Chain straight into the next LOAD so consecutive fills
                    // are separated by a single non-plot cycle.
                    state_d = (vga.enable && |dirty) ? S_LOAD : S_IDLE;
                end else begin
                    if (col_q == X_W'(KEY_W - 1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    x_d    = base_x_q + col_d;
                    y_d    = Y_W'(KEY_Y) + row_d;
                    plot_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and registered pixel-port outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            drawn_q  <= '0;
            last_q   <= '0;
            base_x_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
        end else begin
            drawn_q  <= drawn_d;
            last_q   <= last_d;
            base_x_q <= base_x_d;
            col_q    <= col_d;
            row_q    <= row_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
        end
    end

    assign vga.x      = x_q;
    assign vga.y      = y_q;
    assign vga.colour = colour_q;
    assign vga.plot   = plot_q;
    assign vga.busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_piano_key_renderer.sv
// Directed bench for piano_key_renderer with default parameters.
module tb_piano_key_renderer;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    piano_key_renderer_if #(.NUM_KEYS(8), .X_W(8), .Y_W(7)) bus ();

    piano_key_renderer dut (
        .clk    (clk),
        .resetn (resetn),
        .vga    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed colour for key i: 1 + (i mod 7).
    function automatic logic [2:0] key_colour(input int i);
        return 3'((i % 7) + 1);
    endfunction

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a fill to start, then check all 128 pixels in raster
    // order. Optionally drives key_n[act_key]=act_val while pixel act_at is shown.
    task automatic expect_fill(input string tag, input int key, input logic [2:0] col,
                               input int budget, input int act_at, input int act_key,
                               input logic act_val, output int waited);
        int n;
        n = 0;
        while (bus.plot !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        waited = n;
        checks++;
        if (bus.plot !== 1'b1) begin
            failures++;
            $display("FAIL %s start: plot=%b after %0d cycles, required 1", tag, bus.plot, n);
            return;
        end
        for (int p = 0; p < 128; p++) begin
            logic [7:0] ex;
            logic [6:0] ey;
            ex = 8'(key * 16 + p % 16);
            ey = 7'(87 + p / 16);
            checks++;
            if (bus.plot !== 1'b1 || bus.busy !== 1'b1 || bus.x !== ex ||
                bus.y !== ey || bus.colour !== col) begin
                failures++;
                $display("FAIL %s pixel %0d: plot=%b busy=%b x=%0d y=%0d colour=%b, required plot=1 busy=1 x=%0d y=%0d colour=%b",
                         tag, p, bus.plot, bus.busy, bus.x, bus.y, bus.colour, ex, ey, col);
            end
            if (p == act_at) bus.key_n[act_key] = act_val;
            step();
        end
    endtask

    // Let pending work finish; busy must drop within a bounded time.
    task automatic drain(input string tag);
        int n;
        repeat (4) step();
        n = 0;
        while (bus.busy !== 1'b0 && n < 2000) begin
            step();
            n++;
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s drain: busy=%b after %0d cycles, required 0", tag, bus.busy, n);
        end
    endtask

    task automatic test_reset();
        int bad;
        resetn     = 1'b0;
        bus.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.key_n = 8'($urandom);
            step();
            checks++;
            if ({bus.x, bus.y, bus.colour, bus.plot, bus.busy} !== 20'd0) begin
                failures++;
                $display("FAIL reset_state cycle %0d: x=%0d y=%0d colour=%b plot=%b busy=%b, required all 0",
                         i, bus.x, bus.y, bus.colour, bus.plot, bus.busy);
            end
        end
        bus.key_n = '1;
        resetn    = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus.plot !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_quiet: %0d cycles with plot/busy set, required 0", bad);
        end
    endtask

    task automatic test_single_press();
        int w;
        @(negedge clk);
        bus.key_n[0] = 1'b0;
        // Sampling edge N is the next posedge; plot rises on edge N+3 and is
        // captured by the adapter on edge N+4, i.e. seen on the 4th sample.
        expect_fill("press0", 0, key_colour(0), 10, -1, 0, 1'b0, w);
        checks++;
        if (w != 4) begin
            failures++;
            $display("FAIL press0_latency: first plot on sample %0d, required 4", w);
        end
        checks++;
        if (bus.plot !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL press0_end: plot=%b busy=%b, required 0 0", bus.plot, bus.busy);
        end
        @(negedge clk);
        bus.key_n[0] = 1'b1;
        expect_fill("release0", 0, 3'b000, 10, -1, 0, 1'b0, w);
        drain("single");
    endtask

    task automatic test_simultaneous();
        int w;
        @(negedge clk);
        bus.key_n[2] = 1'b0;
        bus.key_n[5] = 1'b0;
        expect_fill("sim_k2", 2, key_colour(2), 10, -1, 0, 1'b0, w);
        checks++;
        if (bus.plot !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL sim_gap: plot=%b busy=%b, required plot=0 busy=1", bus.plot, bus.busy);
        end
        expect_fill("sim_k5", 5, key_colour(5), 2, -1, 0, 1'b0, w);
        checks++;
        if (w != 1) begin
            failures++;
            $display("FAIL sim_gap_len: gap %0d cycles, required 1", w);
        end
        drain("simultaneous");
    endtask

    task automatic test_round_robin();
        int w;
        // Keys 2 and 5 are still held and drawn; last served is 5.
        @(negedge clk);
        bus.key_n[1] = 1'b0;
        bus.key_n[3] = 1'b0;
        bus.key_n[6] = 1'b0;
        expect_fill("rr_k6", 6, key_colour(6), 10, -1, 0, 1'b0, w);
        expect_fill("rr_k1", 1, key_colour(1), 2, -1, 0, 1'b0, w);
        checks++;
        if (w != 1) begin
            failures++;
            $display("FAIL rr_gap: gap %0d cycles, required 1", w);
        end
        expect_fill("rr_k3", 3, key_colour(3), 2, -1, 0, 1'b0, w);
        drain("rr_press");
        @(negedge clk);
        bus.key_n = '1;
        drain("rr_release");
    endtask

    task automatic test_change_mid_fill();
        int w;
        int bad;
        @(negedge clk);
        bus.key_n[7] = 1'b0;
        expect_fill("mid_press7", 7, key_colour(7), 10, 40, 7, 1'b1, w);
        expect_fill("mid_redraw7", 7, 3'b000, 2, -1, 0, 1'b0, w);
        checks++;
        if (w != 1) begin
            failures++;
            $display("FAIL mid_gap: gap %0d cycles, required 1", w);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.plot !== 1'b0 || bus.busy !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mid_settled: %0d cycles with plot/busy after redraw, required 0", bad);
        end
    endtask

    task automatic test_reset_mid_fill();
        int w;
        int n;
        @(negedge clk);
        bus.key_n[3] = 1'b0;
        n = 0;
        while (bus.plot !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        repeat (60) step();
        checks++;
        if (bus.plot !== 1'b1 || bus.x !== 8'd60 || bus.y !== 7'd90) begin
            failures++;
            $display("FAIL rstmid_pixel60: plot=%b x=%0d y=%0d, required 1 60 90", bus.plot, bus.x, bus.y);
        end
        resetn = 1'b0;
        step();
        checks++;
        if (bus.plot !== 1'b0 || bus.busy !== 1'b0 || bus.x !== 8'd0 || bus.y !== 7'd0) begin
            failures++;
            $display("FAIL rstmid_abort: plot=%b busy=%b x=%0d y=%0d, required 0 0 0 0",
                     bus.plot, bus.busy, bus.x, bus.y);
        end
        resetn = 1'b1;
        expect_fill("rstmid_redraw3", 3, key_colour(3), 10, -1, 0, 1'b0, w);
        checks++;
        if (w != 4) begin
            failures++;
            $display("FAIL rstmid_latency: first plot on sample %0d, required 4", w);
        end
        @(negedge clk);
        bus.key_n[3] = 1'b1;
        expect_fill("rstmid_release3", 3, 3'b000, 10, -1, 0, 1'b0, w);
        drain("reset_mid");
    endtask

    task automatic test_enable_hold();
        int w;
        int bad;
        @(negedge clk);
        bus.enable   = 1'b0;
        bus.key_n[4] = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.plot !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_quiet: %0d cycles with plot/busy while disabled, required 0", bad);
        end
        bus.enable = 1'b1;
        step();
        checks++;
        if (bus.busy !== 1'b1 || bus.plot !== 1'b0) begin
            failures++;
            $display("FAIL hold_load: busy=%b plot=%b, required busy=1 plot=0", bus.busy, bus.plot);
        end
        expect_fill("hold_k4", 4, key_colour(4), 2, -1, 0, 1'b0, w);
        checks++;
        if (w != 1) begin
            failures++;
            $display("FAIL hold_latency: first plot %0d cycles after load, required 1", w);
        end
        @(negedge clk);
        bus.key_n[4] = 1'b1;
        expect_fill("hold_release4", 4, 3'b000, 10, -1, 0, 1'b0, w);
        drain("enable_hold");
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        resetn     = 1'b0;
        bus.key_n  = '1;
        bus.enable = 1'b1;

        test_reset();
        test_single_press();
        test_simultaneous();
        test_round_robin();
        test_change_mid_fill();
        test_reset_mid_fill();
        test_enable_hold();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
